// File: rtl/eth_metadata_queue.sv
// rtl/eth_metadata_queue.sv - per-frame Ethernet metadata assembler with complete-frame FIFO
package eth_metadata_pkg;
    typedef logic [47:0] mac_addr_t;
    typedef logic [15:0] ethertype_t;

    typedef struct packed {
        mac_addr_t  dest_mac;
        mac_addr_t  src_mac;
        ethertype_t ethertype;
        logic [11:0] vlan_id;
        logic [4:0]  l2_header_len;
        logic        vlan_present;
        logic        is_ipv4;
        logic        is_ipv6;
        logic        is_arp;
        logic        is_unknown;
    } eth_metadata_t;
endpackage

module eth_metadata_queue
    import eth_metadata_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ID_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic                     frame_end,
    input  logic                     frame_error,
    input  logic                     fields_valid,
    input  mac_addr_t                dest_mac,
    input  mac_addr_t                src_mac,
    input  logic                     vlan_valid,
    input  logic                     vlan_present,
    input  logic [11:0]              vlan_id,
    input  ethertype_t               resolved_ethertype,
    input  logic [4:0]               l2_header_len,
    input  logic                     proto_valid,
    input  logic                     is_ipv4,
    input  logic                     is_ipv6,
    input  logic                     is_arp,
    input  logic                     is_unknown,
    output eth_metadata_t            m_metadata,
    output logic [ID_W-1:0]          m_frame_id,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     busy,
    output logic [CNT_W-1:0]         drop_incomplete,
    output logic [CNT_W-1:0]         drop_overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int REC_W = $bits(eth_metadata_t);

    typedef enum logic {S_IDLE, S_COLLECT} state_t;

    state_t            state_q, state_d;
    eth_metadata_t     rec_q, rec_d, rec_m;
    logic              hdr_q, hdr_d, hdr_m;
    logic              vlan_q, vlan_d, vlan_m;
    logic              proto_q, proto_d, proto_m;
    logic              err_q, err_d, err_m;
    logic [ID_W-1:0]   frame_id_q, frame_id_d;
    logic [ID_W-1:0]   id_cnt_q, id_cnt_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  drop_inc_q, drop_inc_d;
    logic [CNT_W-1:0]  drop_ovf_q, drop_ovf_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [REC_W+ID_W-1:0] mem_q [DEPTH];
    logic [REC_W+ID_W-1:0] head;

    logic start, commit, complete, full, push, pop, inc_incomplete, inc_overflow;

    assign full = (occ_q == OCC_W'(DEPTH));
    assign pop  = m_valid && m_ready;

    always_comb begin
        // Staging record with this cycle's strobes merged, so a commit sees them.
        rec_m   = rec_q;
        hdr_m   = hdr_q;
        vlan_m  = vlan_q;
        proto_m = proto_q;
        err_m   = err_q | frame_error;
        if (state_q == S_COLLECT) begin
            if (fields_valid) begin
                rec_m.dest_mac = dest_mac;
                rec_m.src_mac  = src_mac;
                hdr_m          = 1'b1;
            end
            if (vlan_valid) begin
                rec_m.vlan_present  = vlan_present;
                rec_m.vlan_id       = vlan_id;
                rec_m.ethertype     = resolved_ethertype;
                rec_m.l2_header_len = l2_header_len;
                vlan_m              = 1'b1;
            end
            if (proto_valid) begin
                rec_m.is_ipv4    = is_ipv4;
                rec_m.is_ipv6    = is_ipv6;
                rec_m.is_arp     = is_arp;
                rec_m.is_unknown = is_unknown;
                proto_m          = 1'b1;
            end
        end
        complete = hdr_m && vlan_m && proto_m && !err_m;
    end

    always_comb begin
        state_d        = state_q;
        rec_d          = rec_q;
        hdr_d          = hdr_q;
        vlan_d         = vlan_q;
        proto_d        = proto_q;
        err_d          = err_q;
        frame_id_d     = frame_id_q;
        id_cnt_d       = id_cnt_q;
        start          = 1'b0;
        commit         = 1'b0;
        inc_incomplete = 1'b0;
        inc_overflow   = 1'b0;
        push           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_start && frame_end) begin
                    inc_incomplete = 1'b1;
                    id_cnt_d       = id_cnt_q + ID_W'(1);
                end else if (frame_start) begin
                    start = 1'b1;
                end
            end
            S_COLLECT: begin
                rec_d   = rec_m;
                hdr_d   = hdr_m;
                vlan_d  = vlan_m;
                proto_d = proto_m;
                err_d   = err_m;
                if (frame_end) begin
                    commit = 1'b1;
                    if (!frame_start) state_d = S_IDLE;
                end else if (frame_start) begin
                    inc_incomplete = 1'b1;
                end
                start = frame_start;
            end
            default: state_d = S_IDLE;
        endcase

        if (start) begin
            state_d    = S_COLLECT;
            rec_d      = '0;
            hdr_d      = 1'b0;
            vlan_d     = 1'b0;
            proto_d    = 1'b0;
            err_d      = 1'b0;
            frame_id_d = id_cnt_q;
            id_cnt_d   = id_cnt_q + ID_W'(1);
        end

        if (commit) begin
            if (!complete)          inc_incomplete = 1'b1;
            else if (full && !pop)  inc_overflow   = 1'b1;
            else                    push           = 1'b1;
        end
    end

    always_comb begin
        busy_d     = (state_d == S_COLLECT);
        drop_inc_d = (inc_incomplete && drop_inc_q != '1) ? drop_inc_q + CNT_W'(1) : drop_inc_q;
        drop_ovf_d = (inc_overflow && drop_ovf_q != '1) ? drop_ovf_q + CNT_W'(1) : drop_ovf_q;
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        occ_d      = occ_q;
        if (push && !pop)      occ_d = occ_q + OCC_W'(1);
        else if (!push && pop) occ_d = occ_q - OCC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rec_q      <= '0;
            hdr_q      <= 1'b0;
            vlan_q     <= 1'b0;
            proto_q    <= 1'b0;
            err_q      <= 1'b0;
            frame_id_q <= '0;
            id_cnt_q   <= '0;
            busy_q     <= 1'b0;
            drop_inc_q <= '0;
            drop_ovf_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
        end else begin
            state_q    <= state_d;
            rec_q      <= rec_d;
            hdr_q      <= hdr_d;
            vlan_q     <= vlan_d;
            proto_q    <= proto_d;
            err_q      <= err_d;
            frame_id_q <= frame_id_d;
            id_cnt_q   <= id_cnt_d;
            busy_q     <= busy_d;
            drop_inc_q <= drop_inc_d;
            drop_ovf_q <= drop_ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
        end
    end

    // Storage needs no reset: outputs are masked by m_valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {rec_m, frame_id_q};
    end

    assign head            = mem_q[rd_ptr_q];
    assign m_valid         = (occ_q != '0);
    assign m_metadata      = m_valid ? eth_metadata_t'(head[REC_W+ID_W-1:ID_W]) : '0;
    assign m_frame_id      = m_valid ? head[ID_W-1:0] : '0;
    assign occupancy       = occ_q;
    assign busy            = busy_q;
    assign drop_incomplete = drop_inc_q;
    assign drop_overflow   = drop_ovf_q;
endmodule

// File: tb/tb_eth_metadata_queue.sv
// tb/tb_eth_metadata_queue.sv - directed self-checking bench for eth_metadata_queue
module tb_eth_metadata_queue;
    import eth_metadata_pkg::*;

    localparam int DEPTH = 4;
    localparam int ID_W  = 8;
    localparam int CNT_W = 16;

    logic clk, rst;
    logic frame_start, frame_end, frame_error;
    logic fields_valid, vlan_valid, proto_valid;
    mac_addr_t dest_mac, src_mac;
    logic vlan_present;
    logic [11:0] vlan_id;
    ethertype_t resolved_ethertype;
    logic [4:0] l2_header_len;
    logic is_ipv4, is_ipv6, is_arp, is_unknown;
    eth_metadata_t m_metadata;
    logic [ID_W-1:0] m_frame_id;
    logic m_valid, m_ready;
    logic [$clog2(DEPTH):0] occupancy;
    logic busy;
    logic [CNT_W-1:0] drop_incomplete, drop_overflow;

    int checks = 0;
    int errors = 0;

    eth_metadata_t rec_a, rec_b;
    logic [ID_W-1:0] head_id;

    eth_metadata_queue #(.DEPTH(DEPTH), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .frame_start(frame_start), .frame_end(frame_end), .frame_error(frame_error),
        .fields_valid(fields_valid), .dest_mac(dest_mac), .src_mac(src_mac),
        .vlan_valid(vlan_valid), .vlan_present(vlan_present), .vlan_id(vlan_id),
        .resolved_ethertype(resolved_ethertype), .l2_header_len(l2_header_len),
        .proto_valid(proto_valid), .is_ipv4(is_ipv4), .is_ipv6(is_ipv6),
        .is_arp(is_arp), .is_unknown(is_unknown),
        .m_metadata(m_metadata), .m_frame_id(m_frame_id),
        .m_valid(m_valid), .m_ready(m_ready),
        .occupancy(occupancy), .busy(busy),
        .drop_incomplete(drop_incomplete), .drop_overflow(drop_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_record(input eth_metadata_t r);
        dest_mac           = r.dest_mac;
        src_mac            = r.src_mac;
        vlan_present       = r.vlan_present;
        vlan_id            = r.vlan_id;
        resolved_ethertype = r.ethertype;
        l2_header_len      = r.l2_header_len;
        is_ipv4            = r.is_ipv4;
        is_ipv6            = r.is_ipv6;
        is_arp             = r.is_arp;
        is_unknown         = r.is_unknown;
    endtask

    task automatic strobes(input logic f, input logic v, input logic p);
        fields_valid = f;
        vlan_valid   = v;
        proto_valid  = p;
    endtask

    // Complete two-cycle frame: start, then all strobes with frame_end.
    task automatic send_frame;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        load_record(rec_a);
        strobes(1, 1, 1);
        frame_end = 1'b1;
        tick();
        strobes(0, 0, 0);
        frame_end = 1'b0;
    endtask

    initial begin
        rec_a = '{dest_mac: 48'h001122334455, src_mac: 48'h66778899aabb, ethertype: 16'h0800,
                  vlan_id: 12'd100, l2_header_len: 5'd18, vlan_present: 1'b1,
                  is_ipv4: 1'b1, is_ipv6: 1'b0, is_arp: 1'b0, is_unknown: 1'b0};
        rec_b = '{dest_mac: 48'hffffffffffff, src_mac: 48'h020000000001, ethertype: 16'h0806,
                  vlan_id: 12'd0, l2_header_len: 5'd14, vlan_present: 1'b0,
                  is_ipv4: 1'b0, is_ipv6: 1'b0, is_arp: 1'b1, is_unknown: 1'b0};
        rst = 1'b1; frame_start = 0; frame_end = 0; frame_error = 0; m_ready = 0;
        strobes(0, 0, 0);
        load_record('0);
        tick(); tick();
        rst = 1'b0;

        check("rst_valid", m_valid, 0);
        check("rst_occ", occupancy, 0);
        check("rst_busy", busy, 0);
        check("rst_dinc", drop_incomplete, 0);
        check("rst_dovf", drop_overflow, 0);
        check("rst_meta", m_metadata, 0);
        check("rst_id", m_frame_id, 0);

        // Single frame, strobes on separate cycles.
        frame_start = 1; tick(); frame_start = 0;
        check("t1_busy", busy, 1);
        load_record(rec_a);
        strobes(1, 0, 0); tick();
        strobes(0, 1, 0); tick();
        strobes(0, 0, 1); tick();
        strobes(0, 0, 0);
        check("t1_novalid", m_valid, 0);
        frame_end = 1; tick(); frame_end = 0;
        check("t1_valid", m_valid, 1);
        check("t1_id", m_frame_id, 0);
        check("t1_meta", m_metadata, rec_a);
        check("t1_occ", occupancy, 1);
        check("t1_idle", busy, 0);
        m_ready = 1; tick(); m_ready = 0;
        check("t1_pop", occupancy, 0);

        // All strobes together with frame_end.
        frame_start = 1; tick(); frame_start = 0;
        load_record(rec_b);
        strobes(1, 1, 1); frame_end = 1; tick();
        strobes(0, 0, 0); frame_end = 0;
        check("t2_id", m_frame_id, 1);
        check("t2_meta", m_metadata, rec_b);
        check("t2_dinc", drop_incomplete, 0);
        m_ready = 1; tick(); m_ready = 0;

        // Missing proto, then errored frame.
        frame_start = 1; tick(); frame_start = 0;
        load_record(rec_a);
        strobes(1, 1, 0); tick(); strobes(0, 0, 0);
        frame_end = 1; tick(); frame_end = 0;
        check("t3_dinc1", drop_incomplete, 1);
        check("t3_novalid", m_valid, 0);
        frame_start = 1; tick(); frame_start = 0;
        strobes(1, 1, 1); frame_error = 1; tick(); strobes(0, 0, 0); frame_error = 0;
        frame_end = 1; tick(); frame_end = 0;
        check("t3_dinc2", drop_incomplete, 2);
        check("t3_occ", occupancy, 0);

        // frame_end and frame_start in one cycle: ids 4 and 5.
        frame_start = 1; tick();
        strobes(1, 1, 1); frame_end = 1; tick();
        frame_start = 0;
        check("t4_busy", busy, 1);
        check("t4_occ1", occupancy, 1);
        check("t4_head", m_frame_id, 4);
        tick(); strobes(0, 0, 0); frame_end = 0;
        check("t4_occ2", occupancy, 2);
        m_ready = 1; tick();
        check("t4_next", m_frame_id, 5);
        tick(); m_ready = 0;
        check("t4_empty", occupancy, 0);

        // Overflow: ids 6..10, id 10 dropped, head stays at 6.
        for (int i = 0; i < DEPTH + 1; i++) begin
            send_frame();
            check("t5_head", m_frame_id, 6);
            check("t5_meta", m_metadata, rec_a);
        end
        check("t5_occ", occupancy, DEPTH);
        check("t5_dovf", drop_overflow, 1);
        frame_start = 1; tick(); frame_start = 0;
        strobes(1, 1, 1); frame_end = 1; m_ready = 1; tick();
        strobes(0, 0, 0); frame_end = 0; m_ready = 0;
        check("t5_full_pp_occ", occupancy, DEPTH);
        check("t5_full_pp_dovf", drop_overflow, 1);
        begin
            logic [ID_W-1:0] order [4];
            order[0] = 7; order[1] = 8; order[2] = 9; order[3] = 11;
            m_ready = 1;
            for (int i = 0; i < 4; i++) begin
                check("t5_order", m_frame_id, order[i]);
                tick();
            end
            m_ready = 0;
        end
        check("t5_drained", occupancy, 0);

        // frame_start inside COLLECT discards open frame (12), commits 13.
        frame_start = 1; tick(); frame_start = 0;
        strobes(1, 0, 0); tick(); strobes(0, 0, 0);
        frame_start = 1; tick(); frame_start = 0;
        check("t6_dinc", drop_incomplete, 3);
        check("t6_busy", busy, 1);
        strobes(1, 1, 1); frame_end = 1; tick(); strobes(0, 0, 0); frame_end = 0;
        check("t6_id", m_frame_id, 13);
        m_ready = 1; tick(); m_ready = 0;

        // Run ids 14..255 and wrap to 0, 1.
        for (int i = 14; i < 258; i++) begin
            send_frame();
            head_id = ID_W'(i);
            check("t7_wrap_id", m_frame_id, head_id);
            m_ready = 1; tick(); m_ready = 0;
        end
        check("t7_occ", occupancy, 0);

        // Reset mid-COLLECT with two queued entries.
        send_frame();
        send_frame();
        frame_start = 1; tick(); frame_start = 0;
        strobes(1, 0, 0); tick(); strobes(0, 0, 0);
        check("t8_pre_occ", occupancy, 2);
        check("t8_pre_busy", busy, 1);
        rst = 1; tick(); rst = 0;
        check("t8_valid", m_valid, 0);
        check("t8_occ", occupancy, 0);
        check("t8_busy", busy, 0);
        check("t8_dinc", drop_incomplete, 0);
        check("t8_dovf", drop_overflow, 0);
        check("t8_meta", m_metadata, 0);
        send_frame();
        check("t8_id0", m_frame_id, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
